sprite_compositor: RTL and testbench

- Sits directly upstream and downstream of the 16x16 RGBA sprite lookup (line/column in, 1-bit R/G/B/A out). It turns VGA beam coordinates into sprite line/column, takes the returned RGBA pixel and blends it over the background colour.
- Also owns the sprite's position: it bounces the sprite around the active area, updating once per frame during vertical blanking.
- Output feeds the VGA pin registers.

---
 rtl/sprite_compositor_pkg.sv | 31 +++
 rtl/sprite_motion.sv | 89 ++++++++
 rtl/sprite_compositor.sv | 122 ++++++++++++
 tb/tb_sprite_compositor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared constants and helpers for the sprite compositor and its motion unit.
package sprite_compositor_pkg;

    localparam int SPRITE_SIZE = 16;
    localparam int SPRITE_BITS = 4;
    localparam int COORD_W     = 10;

    // Colour bit positions within a 3-bit {R,G,B} word
    localparam int RGB_R = 2;
    localparam int RGB_G = 1;
    localparam int RGB_B = 0;

    // Motion direction encoding, one per axis
    localparam logic [0:0] DIR_INC = 1'b0;
    localparam logic [0:0] DIR_DEC = 1'b1;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    // Limit a requested coordinate to the largest legal sprite edge
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Per-axis sprite position: bounces between 0 and ACTIVE-16 once per frame
// tick, or commits a pending loaded position instead of moving.
module sprite_motion
    import sprite_compositor_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int SPEED  = 1,
    parameter int INIT   = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               i_move_en,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_load_val,
    output logic [COORD_W-1:0] o_pos,
    output logic [0:0]         o_dir
);

    localparam logic [COORD_W-1:0] MAX_POS = COORD_W'(ACTIVE - SPRITE_SIZE);
    localparam logic [COORD_W-1:0] STEP    = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] INIT_C  = COORD_W'(INIT);

    logic [COORD_W-1:0] r_pos;
    logic [0:0]         r_dir;
    logic               r_pend;
    logic [COORD_W-1:0] r_pend_val;

    logic [COORD_W:0]   w_sum;
    logic [COORD_W-1:0] w_next_pos;
    logic [0:0]         w_next_dir;

    // Extra bit on the sum keeps the upper-bound compare free of wrap
    assign w_sum = {1'b0, r_pos} + {1'b0, STEP};

    // Next position/direction if motion is applied at this tick
    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        case (r_dir)
            DIR_INC: begin
                if (w_sum >= {1'b0, MAX_POS}) begin
                    w_next_pos = MAX_POS;
                    w_next_dir = DIR_DEC;
                end else begin
                    w_next_pos = w_sum[COORD_W-1:0];
                end
            end
            default: begin
                if (r_pos <= STEP) begin
                    w_next_pos = '0;
                    w_next_dir = DIR_INC;
                end else begin
                    w_next_pos = r_pos - STEP;
                end
            end
        endcase
    end

    // Position/direction update at the frame tick, plus pending-load capture;
    // a load on the tick cycle wins over clearing pend so it survives to the next tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos      <= INIT_C;
            r_dir      <= DIR_INC;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else begin
            if (i_tick) begin
                if (r_pend) begin
                    r_pos <= r_pend_val;
                end else if (i_move_en) begin
                    r_pos <= w_next_pos;
                    r_dir <= w_next_dir;
                end
            end
            if (i_load) begin
                r_pend     <= 1'b1;
                r_pend_val <= clamp_coord(i_load_val, MAX_POS);
            end else if (i_tick) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pos = r_pos;
    assign o_dir = r_dir;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel pipeline: beam -> sprite line/column, then lookup result
// blended over the background. Sprite position owned by two motion units.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPEED    = 1,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_W-1:0]     hpos,
    input  logic [COORD_W-1:0]     vpos,
    input  logic                   display_on,
    input  logic [2:0]             bg_rgb,
    input  logic                   move_en,
    input  logic                   load_pos,
    input  logic [COORD_W-1:0]     load_x,
    input  logic [COORD_W-1:0]     load_y,
    output logic [SPRITE_BITS-1:0] sprite_line,
    output logic [SPRITE_BITS-1:0] sprite_column,
    input  logic                   sprite_r,
    input  logic                   sprite_g,
    input  logic                   sprite_b,
    input  logic                   sprite_a,
    output logic [2:0]             rgb_out,
    output logic [COORD_W-1:0]     sprite_x,
    output logic [COORD_W-1:0]     sprite_y
);

    localparam logic [COORD_W-1:0] V_TICK = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(SPRITE_SIZE);

    logic               w_tick;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic               w_in_box;
    logic [0:0]         w_dir_x;
    logic [0:0]         w_dir_y;
    rgb_t               w_sprite_rgb;

    logic               r_valid1;
    logic               r_in_box;
    logic               r_disp_d;
    rgb_t               r_bg_d;

    assign w_tick = (hpos == '0) && (vpos == V_TICK);

    // Unsigned wrap makes beam positions left of / above the sprite fall out of the box
    assign w_dx     = hpos - sprite_x;
    assign w_dy     = vpos - sprite_y;
    assign w_in_box = (w_dx < SIZE_C) && (w_dy < SIZE_C);

    assign w_sprite_rgb = '{r: sprite_r, g: sprite_g, b: sprite_b};

    sprite_motion #(
        .ACTIVE (H_ACTIVE),
        .SPEED  (SPEED),
        .INIT   (X_INIT)
    ) u_motion_x (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (w_tick),
        .i_move_en  (move_en),
        .i_load     (load_pos),
        .i_load_val (load_x),
        .o_pos      (sprite_x),
        .o_dir      (w_dir_x)
    );

    sprite_motion #(
        .ACTIVE (V_ACTIVE),
        .SPEED  (SPEED),
        .INIT   (Y_INIT)
    ) u_motion_y (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (w_tick),
        .i_move_en  (move_en),
        .i_load     (load_pos),
        .i_load_val (load_y),
        .o_pos      (sprite_y),
        .o_dir      (w_dir_y)
    );

    // Stage 1: lookup address and in-box flag, with beam attributes delayed alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid1      <= 1'b0;
            r_in_box      <= 1'b0;
            r_disp_d      <= 1'b0;
            r_bg_d        <= '0;
            sprite_line   <= '0;
            sprite_column <= '0;
        end else begin
            r_valid1      <= 1'b1;
            r_in_box      <= w_in_box;
            r_disp_d      <= display_on;
            r_bg_d        <= bg_rgb;
            sprite_line   <= w_dy[SPRITE_BITS-1:0];
            sprite_column <= w_dx[SPRITE_BITS-1:0];
        end
    end

    // Stage 2: opaque sprite pixels win over background; blank outside active area
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out <= '0;
        end else if (r_valid1 && r_disp_d) begin
            if (r_in_box && sprite_a) begin
                rgb_out <= w_sprite_rgb;
            end else begin
                rgb_out <= r_bg_d;
            end
        end else begin
            rgb_out <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: table-driven pixel vectors plus
// hand-written motion, load and reset sequences.
module tb_sprite_compositor;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on;
    logic [2:0] bg_rgb;
    logic       move_en;
    logic       load_pos;
    logic [9:0] load_x, load_y;
    logic [3:0] sprite_line, sprite_column;
    logic       sprite_r, sprite_g, sprite_b, sprite_a;
    logic [2:0] rgb_out;
    logic [9:0] sprite_x, sprite_y;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       d;
        logic [2:0] bg;
        logic [2:0] lut;
        logic       a;
        logic [2:0] exp_rgb;
        logic [3:0] exp_line;
        logic [3:0] exp_col;
    } vec_t;

    vec_t vecs[8];

    sprite_compositor #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .SPEED    (1),
        .X_INIT   (100),
        .Y_INIT   (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hpos          (hpos),
        .vpos          (vpos),
        .display_on    (display_on),
        .bg_rgb        (bg_rgb),
        .move_en       (move_en),
        .load_pos      (load_pos),
        .load_x        (load_x),
        .load_y        (load_y),
        .sprite_line   (sprite_line),
        .sprite_column (sprite_column),
        .sprite_r      (sprite_r),
        .sprite_g      (sprite_g),
        .sprite_b      (sprite_b),
        .sprite_a      (sprite_a),
        .rgb_out       (rgb_out),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_px(input logic [9:0] h, input logic [9:0] v, input logic d,
                          input logic [2:0] bg, input logic [2:0] lut, input logic a);
        hpos = h; vpos = v; display_on = d; bg_rgb = bg;
        {sprite_r, sprite_g, sprite_b} = lut;
        sprite_a = a;
    endtask

    // One frame-tick cycle, driven from negedge to negedge
    task automatic tick(input logic mv);
        @(negedge clk);
        hpos = 10'd0; vpos = 10'd480; display_on = 1'b0; move_en = mv;
        @(negedge clk);
        hpos = 10'd5; vpos = 10'd5; move_en = 1'b0;
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        load_pos = 1'b1; load_x = x; load_y = y;
        @(negedge clk);
        load_pos = 1'b0;
    endtask

    task automatic chk_pos(input string name, input logic [9:0] x, input logic [9:0] y);
        chk({name, "_x"}, 32'(sprite_x), 32'(x));
        chk({name, "_y"}, 32'(sprite_y), 32'(y));
    endtask

    initial begin
        //             h    v    d  bg      lut     a  rgb     line col
        vecs[0] = '{10'd100, 10'd100, 1'b1, 3'b001, 3'b110, 1'b1, 3'b110, 4'd0,  4'd0};
        vecs[1] = '{10'd115, 10'd115, 1'b1, 3'b001, 3'b011, 1'b1, 3'b011, 4'd15, 4'd15};
        vecs[2] = '{10'd116, 10'd100, 1'b1, 3'b010, 3'b111, 1'b1, 3'b010, 4'd0,  4'd0};
        vecs[3] = '{10'd99,  10'd100, 1'b1, 3'b011, 3'b111, 1'b1, 3'b011, 4'd0,  4'd15};
        vecs[4] = '{10'd105, 10'd107, 1'b1, 3'b101, 3'b111, 1'b0, 3'b101, 4'd7,  4'd5};
        vecs[5] = '{10'd105, 10'd107, 1'b0, 3'b101, 3'b111, 1'b1, 3'b000, 4'd7,  4'd5};
        vecs[6] = '{10'd100, 10'd99,  1'b1, 3'b100, 3'b111, 1'b1, 3'b100, 4'd15, 4'd0};
        vecs[7] = '{10'd0,   10'd0,   1'b1, 3'b111, 3'b000, 1'b1, 3'b111, 4'd12, 4'd12};

        reset = 1'b1; move_en = 1'b0; load_pos = 1'b0; load_x = '0; load_y = '0;
        set_px(10'd5, 10'd5, 1'b0, 3'b000, 3'b000, 1'b0);
        #1;
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_line", 32'(sprite_line), 32'd0);
        chk("rst_col", 32'(sprite_column), 32'd0);
        chk_pos("rst_pos", 10'd100, 10'd100);

        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Pixel pipeline vectors; sprite stays at (100,100) since no tick occurs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_px(vecs[i].h, vecs[i].v, vecs[i].d, vecs[i].bg, vecs[i].lut, vecs[i].a);
            @(posedge clk); #1;
            chk($sformatf("v%0d_line", i), 32'(sprite_line), 32'(vecs[i].exp_line));
            chk($sformatf("v%0d_col", i), 32'(sprite_column), 32'(vecs[i].exp_col));
            @(posedge clk); #1;
            chk($sformatf("v%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
        end
        chk_pos("after_vecs", 10'd100, 10'd100);

        // Hold then move
        tick(1'b0);
        chk_pos("hold", 10'd100, 10'd100);
        tick(1'b1);
        chk_pos("move1", 10'd101, 10'd101);

        // Clamped load waits for the tick and suppresses motion on it
        load(10'd700, 10'd10);
        chk_pos("load_wait", 10'd101, 10'd101);
        tick(1'b1);
        chk_pos("load_commit", 10'd624, 10'd10);

        // Bounce at the upper bounds
        load(10'd623, 10'd463);
        tick(1'b1);
        chk_pos("pre_bounce", 10'd623, 10'd463);
        tick(1'b1);
        chk_pos("bounce_hi", 10'd624, 10'd464);
        tick(1'b1);
        chk_pos("after_hi", 10'd623, 10'd463);

        // Bounce at zero (direction kept DEC across the load)
        load(10'd1, 10'd1);
        tick(1'b1);
        chk_pos("at_one", 10'd1, 10'd1);
        tick(1'b1);
        chk_pos("bounce_lo", 10'd0, 10'd0);
        tick(1'b1);
        chk_pos("after_lo", 10'd1, 10'd1);

        // Load on the tick cycle: older pending commits now, newer on next tick
        load(10'd200, 10'd200);
        @(negedge clk);
        hpos = 10'd0; vpos = 10'd480; display_on = 1'b0; move_en = 1'b1;
        load_pos = 1'b1; load_x = 10'd300; load_y = 10'd300;
        @(negedge clk);
        hpos = 10'd5; vpos = 10'd5; move_en = 1'b0; load_pos = 1'b0;
        chk_pos("tick_load_old", 10'd200, 10'd200);
        tick(1'b1);
        chk_pos("tick_load_new", 10'd300, 10'd300);
        tick(1'b1);
        chk_pos("post_load_move", 10'd301, 10'd301);

        // Drive into DEC on both axes, then reset during an in-box pixel
        load(10'd623, 10'd463);
        tick(1'b1);
        tick(1'b1);
        chk_pos("dec_state", 10'd624, 10'd464);
        @(negedge clk);
        set_px(10'd627, 10'd466, 1'b1, 3'b001, 3'b110, 1'b1);
        @(posedge clk); #1;
        chk("inbox_col", 32'(sprite_column), 32'd3);
        @(posedge clk); #1;
        chk("inbox_rgb", 32'(rgb_out), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rgb", 32'(rgb_out), 32'd0);
        chk("midrst_line", 32'(sprite_line), 32'd0);
        chk("midrst_col", 32'(sprite_column), 32'd0);
        chk_pos("midrst_pos", 10'd100, 10'd100);

        @(negedge clk);
        set_px(10'd100, 10'd100, 1'b1, 3'b001, 3'b110, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_rgb0", 32'(rgb_out), 32'd0);
        @(posedge clk); #1;
        chk("rel_rgb1", 32'(rgb_out), 32'd6);

        // Direction returned to INC on both axes
        tick(1'b1);
        chk_pos("rst_dir", 10'd101, 10'd101);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
